series_accel_ctrl: RTL and testbench
====================================

# series_accel_ctrl

Parametrised control FSM for the iterative series-evaluation accelerator (FPGA datapath with x, term (t) and result (r) registers plus a coefficient ROM). It generalises the fixed two-multiply-per-term sequencer in three ways: configurable term count and multiplies per term, internal term/step counting in place of an external carry-out, and a ready/done handshake. It drives datapath load/clear strobes, the multiplier operand select and the coefficient address.

## Interface
- TERMS, 8: number of series terms accumulated; must be ≥1.
- MULT_STEPS, 2: multiply passes per term; must be ≥1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  cancel request; present only with SERIES_CTRL_ABORT_EN.
- ready  out  1  high in IDLE only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- aborted  out  1  one-cycle pulse after an abort; present only with SERIES_CTRL_ABORT_EN.
- clr_x, clr_t  out  1  clear the x and t registers (IDLE).
- ld_x  out  1  load input x (LOAD).
- init_t, init_r  out  1  preset t and r (INIT).
- ld_t  out  1  load multiplier product into t (MULT).
- ld_r  out  1  accumulate into r (ADD).
- sel  out  SW = max(1, clog2(MULT_STEPS))  multiplier operand select.
- term_idx  out  TW = max(1, clog2(TERMS))  coefficient ROM address.

## Operation
- FSM is Moore; all outputs decode from the state register and counters only.
- States: IDLE, LOAD, INIT, MULT, ADD, DONE.
- IDLE: clr_x = clr_t = 1, ready = 1. Term and step counters are held at 0. Next state is LOAD if start = 1, else IDLE.
- LOAD: ld_x = 1. Next state is INIT.
- INIT: init_t = init_r = 1. Next state is MULT.
- MULT: ld_t = 1, sel = step. Step increments each cycle. On step = MULT_STEPS−1, step wraps to 0 and the next state is ADD.
- ADD: ld_r = 1. On term = TERMS−1 the next state is DONE; otherwise term increments and the next state is MULT.
- DONE: done = 1. Next state is IDLE.
- term_idx = term in every state, and is 0 in IDLE, LOAD and INIT.
- Counters saturate nowhere; they are sized to hold TERMS−1 and MULT_STEPS−1.
- start while busy is ignored; no queuing.
- Out-of-range state encodings decode to IDLE.

## Timing
- Reset values: state IDLE, counters 0. Outputs: ready = clr_x = clr_t = 1, all other outputs 0, term_idx = sel = 0.
- Reset mid-operation returns to IDLE immediately (asynchronous). No done is produced.
- start sampled high at edge k: LOAD occupies cycle k+1, INIT k+2, first MULT k+3.
- done is high in cycle k+3+TERMS·(MULT_STEPS+1). Default configuration gives k+27.
- The earliest next start is sampled in the cycle after DONE.

## Configuration
- SERIES_CTRL_ABORT_EN defined:
  - abort and aborted ports exist.
  - abort = 1 in any non-IDLE state other than DONE forces next state IDLE. aborted pulses for that IDLE cycle and done is not asserted.
  - abort in IDLE or DONE is ignored. start together with abort in IDLE gives start priority.
- SERIES_CTRL_ABORT_EN undefined: ports absent and the run always completes.

## Structure
- series_ctrl_pkg holds:
  - the state enum (3-bit) and its encoding;
  - the SW/TW width helper functions;
  - the LAT_CYCLES constant function 3+TERMS·(MULT_STEPS+1).
- Sub-module ctrl_cnt: generic up-counter with clear, enable, wrap-at-MAX and terminal flag. It is instantiated twice: step (MAX = MULT_STEPS−1) and term (MAX = TERMS−1).

## Test plan
- Reset check: assert rst mid-MULT → outputs return to reset values the same cycle; no done pulse.
- Defaults (8/2), start for 1 cycle at edge k: done exactly at k+27; 8 ld_r pulses; 16 ld_t pulses; sel sequence 0,1 per term; term_idx runs 0..7.
- TERMS=1, MULT_STEPS=1: done at k+5; one ld_t, one ld_r; term_idx stays 0.
- start held high through the whole run and afterwards: a second run begins in the cycle after DONE; no start accepted while busy.
- Abort (macro on): abort in the 3rd MULT cycle → IDLE next cycle, aborted = 1 for one cycle, done never asserted; a new start then completes normally in 27 cycles.
- Macro off: ports absent; compile and run the default scenario with identical results.

Source files
------------

// File: rtl/series_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// series_ctrl_pkg
// Shared definitions for the series-evaluation accelerator control slice:
//   - 3-bit FSM state encoding (legacy-compatible localparam constants)
//   - width helpers for the multiplier select (SW) and term index (TW)
//   - end-to-end latency helper: start edge to DONE cycle
// -----------------------------------------------------------------------------
package series_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_LOAD = 3'd1;
   localparam state_t ST_INIT = 3'd2;
   localparam state_t ST_MULT = 3'd3;
   localparam state_t ST_ADD  = 3'd4;
   localparam state_t ST_DONE = 3'd5;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int sw_width(input int mult_steps);
      return clog2_min1(mult_steps);
   endfunction

   function automatic int tw_width(input int terms);
      return clog2_min1(terms);
   endfunction

   // Cycles from the edge that samples start to the DONE cycle.
   function automatic int lat_cycles(input int terms, input int mult_steps);
      return 3 + terms * (mult_steps + 1);
   endfunction

endpackage

// File: rtl/ctrl_cnt.sv
// -----------------------------------------------------------------------------
// ctrl_cnt
// Generic up-counter: synchronous clear, count enable, wrap to 0 after MAX.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (count -> 0)
//   i_clr    in   synchronous clear, dominates i_en
//   i_en     in   advance the count
//   o_cnt    out  current count [W-1:0]
//   o_tc     out  terminal flag, high while o_cnt == MAX
// -----------------------------------------------------------------------------
module ctrl_cnt #(
   parameter int MAX = 1,
   parameter int W   = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= (r_cnt == MAX_V) ? '0 : r_cnt + W'(1);
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == MAX_V);

endmodule

// File: rtl/series_accel_ctrl.sv
// -----------------------------------------------------------------------------
// series_accel_ctrl
// Moore control FSM for the iterative series-evaluation datapath. Sequences
// LOAD -> INIT -> (MULT x MULT_STEPS -> ADD) x TERMS -> DONE and drives the
// datapath strobes, multiplier operand select and coefficient ROM address.
// Optional feature macro: SERIES_CTRL_ABORT_EN adds i_abort / o_aborted.
// Parameters: TERMS (>=1), MULT_STEPS (>=1).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_start                   run request, sampled only in IDLE
//   i_abort                   cancel request (SERIES_CTRL_ABORT_EN only)
//   o_aborted                 one-cycle pulse after an abort (ditto)
//   o_ready / o_busy          IDLE / any other state
//   o_done                    one-cycle pulse in DONE
//   o_clr_x, o_clr_t          clear x and t (IDLE)
//   o_ld_x                    load x (LOAD)
//   o_init_t, o_init_r        preset t and r (INIT)
//   o_ld_t                    load product into t (MULT)
//   o_ld_r                    accumulate into r (ADD)
//   o_sel [SW-1:0]            multiplier operand select (step in MULT)
//   o_term_idx [TW-1:0]       coefficient ROM address (current term)
// -----------------------------------------------------------------------------
module series_accel_ctrl
   import series_ctrl_pkg::*;
#(
   parameter  int TERMS      = 8,
   parameter  int MULT_STEPS = 2,
   localparam int SW         = sw_width(MULT_STEPS),
   localparam int TW         = tw_width(TERMS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
`ifdef SERIES_CTRL_ABORT_EN
   input  logic          i_abort,
   output logic          o_aborted,
`endif
   output logic          o_ready,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_clr_x,
   output logic          o_clr_t,
   output logic          o_ld_x,
   output logic          o_init_t,
   output logic          o_init_r,
   output logic          o_ld_t,
   output logic          o_ld_r,
   output logic [SW-1:0] o_sel,
   output logic [TW-1:0] o_term_idx
);

   state_t          r_state;
   state_t          w_next;
   logic   [SW-1:0] w_step;
   logic   [TW-1:0] w_term;
   logic            w_step_tc;
   logic            w_term_tc;
   logic            w_abort;
   logic            w_cnt_clr;

`ifdef SERIES_CTRL_ABORT_EN
   logic r_aborted;

   // Abort only cancels a run in progress; DONE always completes.
   assign w_abort = i_abort && (r_state == ST_LOAD || r_state == ST_INIT ||
                                r_state == ST_MULT || r_state == ST_ADD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_aborted <= 1'b0;
      else     r_aborted <= w_abort;
   end

   assign o_aborted = r_aborted;
`else
   assign w_abort = 1'b0;
`endif

   // NOTE: every combinational output gets a default before the case so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_next = ST_IDLE;
      case (r_state)
         ST_LOAD: w_next = ST_INIT;
         ST_INIT: w_next = ST_MULT;
         ST_MULT: w_next = w_step_tc ? ST_ADD : ST_MULT;
         ST_ADD:  w_next = w_term_tc ? ST_DONE : ST_MULT;
         ST_DONE: w_next = ST_IDLE;
         // IDLE and any out-of-range encoding behave as IDLE.
         default: w_next = i_start ? ST_LOAD : ST_IDLE;
      endcase
      if (w_abort) w_next = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Clearing on entry to IDLE keeps both counters at 0 for the whole IDLE
   // stay, while DONE still presents the last term index.
   assign w_cnt_clr = (w_next == ST_IDLE);

   ctrl_cnt #(.MAX(MULT_STEPS - 1), .W(SW)) u_step_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_cnt_clr),
      .i_en  (r_state == ST_MULT),
      .o_cnt (w_step),
      .o_tc  (w_step_tc)
   );

   // The term counter stops at TERMS-1 instead of wrapping; DONE follows.
   ctrl_cnt #(.MAX(TERMS - 1), .W(TW)) u_term_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_cnt_clr),
      .i_en  ((r_state == ST_ADD) && !w_term_tc),
      .o_cnt (w_term),
      .o_tc  (w_term_tc)
   );

   always_comb begin
      o_ready  = 1'b0;
      o_done   = 1'b0;
      o_clr_x  = 1'b0;
      o_clr_t  = 1'b0;
      o_ld_x   = 1'b0;
      o_init_t = 1'b0;
      o_init_r = 1'b0;
      o_ld_t   = 1'b0;
      o_ld_r   = 1'b0;
      o_sel    = '0;
      case (r_state)
         ST_LOAD: o_ld_x = 1'b1;
         ST_INIT: begin
            o_init_t = 1'b1;
            o_init_r = 1'b1;
         end
         ST_MULT: begin
            o_ld_t = 1'b1;
            o_sel  = w_step;
         end
         ST_ADD:  o_ld_r = 1'b1;
         ST_DONE: o_done = 1'b1;
         default: begin
            o_ready = 1'b1;
            o_clr_x = 1'b1;
            o_clr_t = 1'b1;
         end
      endcase
   end

   assign o_busy     = !o_ready;
   assign o_term_idx = w_term;

endmodule

// File: tb/tb_series_accel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_series_accel_ctrl
// Two controller instances (8 terms x 2 steps, 1 term x 1 step) driven with
// randomized start hold times, idle gaps and abort points. Expected outputs
// come from a cycle-offset model of the run schedule.
// -----------------------------------------------------------------------------
module tb_series_accel_ctrl;

   localparam int TA = 8, MA = 2;
   localparam int TB = 1, MB = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_start = 1'b0, b_start = 1'b0;

   logic a_ready, a_busy, a_done, a_clr_x, a_clr_t, a_ld_x, a_init_t, a_init_r, a_ld_t, a_ld_r;
   logic b_ready, b_busy, b_done, b_clr_x, b_clr_t, b_ld_x, b_init_t, b_init_r, b_ld_t, b_ld_r;
   logic [0:0] a_sel, b_sel, b_idx;
   logic [2:0] a_idx;
   logic a_ab, b_ab;

`ifdef SERIES_CTRL_ABORT_EN
   logic a_abort = 1'b0, b_abort = 1'b0;
   logic a_aborted, b_aborted;
   assign a_ab = a_aborted;
   assign b_ab = b_aborted;
`else
   assign a_ab = 1'b0;
   assign b_ab = 1'b0;
`endif

   always #5 clk = ~clk;

   series_accel_ctrl #(.TERMS(TA), .MULT_STEPS(MA)) u_dut_a (
      .clk(clk), .rst(rst), .i_start(a_start),
`ifdef SERIES_CTRL_ABORT_EN
      .i_abort(a_abort), .o_aborted(a_aborted),
`endif
      .o_ready(a_ready), .o_busy(a_busy), .o_done(a_done),
      .o_clr_x(a_clr_x), .o_clr_t(a_clr_t), .o_ld_x(a_ld_x),
      .o_init_t(a_init_t), .o_init_r(a_init_r), .o_ld_t(a_ld_t), .o_ld_r(a_ld_r),
      .o_sel(a_sel), .o_term_idx(a_idx)
   );

   series_accel_ctrl #(.TERMS(TB), .MULT_STEPS(MB)) u_dut_b (
      .clk(clk), .rst(rst), .i_start(b_start),
`ifdef SERIES_CTRL_ABORT_EN
      .i_abort(b_abort), .o_aborted(b_aborted),
`endif
      .o_ready(b_ready), .o_busy(b_busy), .o_done(b_done),
      .o_clr_x(b_clr_x), .o_clr_t(b_clr_t), .o_ld_x(b_ld_x),
      .o_init_t(b_init_t), .o_init_r(b_init_r), .o_ld_t(b_ld_t), .o_ld_r(b_ld_r),
      .o_sel(b_sel), .o_term_idx(b_idx)
   );

   typedef struct packed {
      logic ready, busy, done, aborted, clr_x, clr_t, ld_x, init_t, init_r, ld_t, ld_r;
      logic [7:0] sel;
      logic [7:0] idx;
   } obs_t;

   obs_t obs_a, obs_b;
   assign obs_a = {a_ready, a_busy, a_done, a_ab, a_clr_x, a_clr_t, a_ld_x,
                   a_init_t, a_init_r, a_ld_t, a_ld_r, 8'(a_sel), 8'(a_idx)};
   assign obs_b = {b_ready, b_busy, b_done, b_ab, b_clr_x, b_clr_t, b_ld_x,
                   b_init_t, b_init_r, b_ld_t, b_ld_r, 8'(b_sel), 8'(b_idx)};

   int checks = 0;
   int errors = 0;

   // Expected outputs o cycles after the edge that sampled start. A run is
   // lat+1 cycles long (LOAD .. DONE, then one IDLE); nruns back-to-back runs
   // repeat that pattern. An abort before DONE returns to IDLE with a pulse.
   function automatic obs_t model(input int o, input int t, input int m,
                                  input int nruns, input int abort_at);
      obs_t e;
      int lat, p, q;
      lat = 3 + t * (m + 1);
      e = '0;
      e.ready = 1'b1; e.clr_x = 1'b1; e.clr_t = 1'b1;
      if (abort_at > 0 && abort_at < lat && o > abort_at) begin
         e.aborted = (o == abort_at + 1);
         return e;
      end
      if (o > nruns * (lat + 1)) return e;
      p = (o - 1) % (lat + 1) + 1;
      if (p == lat + 1) return e;
      e.ready = 1'b0; e.clr_x = 1'b0; e.clr_t = 1'b0; e.busy = 1'b1;
      if (p == 1) e.ld_x = 1'b1;
      else if (p == 2) begin
         e.init_t = 1'b1; e.init_r = 1'b1;
      end else if (p == lat) begin
         e.done = 1'b1; e.idx = 8'(t - 1);
      end else begin
         q = p - 3;
         e.idx = 8'(q / (m + 1));
         if (q % (m + 1) < m) begin
            e.ld_t = 1'b1; e.sel = 8'(q % (m + 1));
         end else e.ld_r = 1'b1;
      end
      return e;
   endfunction

   task automatic drive(input int w, input bit s, input bit a);
      if (w == 0) a_start = s; else b_start = s;
`ifdef SERIES_CTRL_ABORT_EN
      if (w == 0) a_abort = a; else b_abort = a;
`endif
   endtask

   // Called at a negedge with the selected DUT idle. start is raised for the
   // IDLE cycle, then held while o < hold; abort is raised during cycle
   // abort_at (abort0 during the initial IDLE cycle).
   task automatic run(input string name, input int w, input int nruns, input int hold,
                      input int abort_at, input bit abort0, input int ncyc);
      int t, m, lat, n_lt, n_lr, n_done, n_ab;
      obs_t got, exp;
      t = (w == 0) ? TA : TB;
      m = (w == 0) ? MA : MB;
      lat = 3 + t * (m + 1);
      n_lt = 0; n_lr = 0; n_done = 0; n_ab = 0;
      drive(w, 1'b1, abort0);
      @(posedge clk);
      for (int o = 1; o <= ncyc; o++) begin
         @(negedge clk);
         got = (w == 0) ? obs_a : obs_b;
         exp = model(o, t, m, nruns, abort_at);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, o, got, exp);
         end
         n_lt += int'(got.ld_t);
         n_lr += int'(got.ld_r);
         n_done += int'(got.done);
         n_ab += int'(got.aborted);
         drive(w, o < hold, o == abort_at);
      end
      drive(w, 1'b0, 1'b0);
      checks++;
      if (abort_at > 0 && abort_at < lat) begin
         if (n_done !== 0 || n_ab !== 1) begin
            errors++;
            $display("FAIL %s abort counts: done %0d aborted %0d want 0 1", name, n_done, n_ab);
         end
      end else if (n_done !== nruns || n_lt !== nruns * t * m || n_lr !== nruns * t) begin
         errors++;
         $display("FAIL %s pulse counts: done %0d ld_t %0d ld_r %0d want %0d %0d %0d",
                  name, n_done, n_lt, n_lr, nruns, nruns * t * m, nruns * t);
      end
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic test_reset();
      obs_t idle;
      int n_done;
      idle = model(1, TA, MA, 0, 0);
      #1;
      checks++;
      if (obs_a !== idle || obs_b !== idle) begin
         errors++;
         $display("FAIL reset_values: got %h %h want %h", obs_a, obs_b, idle);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      drive(0, 1'b1, 1'b0);
      @(posedge clk);
      repeat (4) @(negedge clk);
      drive(0, 1'b0, 1'b0);
      checks++;
      if (a_ld_t !== 1'b1 || a_sel !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_mult: ld_t %b sel %b want 1 1", a_ld_t, a_sel);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs_a !== idle) begin
         errors++;
         $display("FAIL reset_mid_mult: got %h want %h", obs_a, idle);
      end
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         n_done += int'(a_done) + int'(!a_ready);
      end
      checks++;
      if (n_done !== 0) begin
         errors++;
         $display("FAIL reset_no_done: busy/done cycles %0d want 0", n_done);
      end
   endtask

   task automatic test_default();
      for (int i = 0; i < 4; i++) begin
         run("default", 0, 1, $urandom_range(1, 28), 0, 1'b0, 28);
         gap();
      end
   endtask

   task automatic test_minimal();
      for (int i = 0; i < 4; i++) begin
         run("minimal", 1, 1, $urandom_range(1, 6), 0, 1'b0, 6);
         gap();
      end
   endtask

   task automatic test_back_to_back();
      run("b2b_default", 0, 2, 56, 0, 1'b0, 57);
      gap();
      run("b2b_minimal", 1, 2, 12, 0, 1'b0, 13);
      gap();
   endtask

`ifdef SERIES_CTRL_ABORT_EN
   task automatic test_abort();
      int at;
      run("abort_mult3", 0, 1, 1, 6, 1'b0, 8);
      run("after_abort", 0, 1, 1, 0, 1'b0, 28);
      for (int i = 0; i < 3; i++) begin
         at = $urandom_range(1, 26);
         run("abort_rand", 0, 1, 1, at, 1'b0, at + 2);
         gap();
      end
      at = $urandom_range(1, 4);
      run("abort_min", 1, 1, 1, at, 1'b0, at + 2);
      run("abort_in_done", 0, 1, 1, 27, 1'b0, 28);
      run("start_over_abort", 0, 1, 1, 0, 1'b1, 28);
      drive(0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      drive(0, 1'b0, 1'b0);
      checks++;
      if (a_ready !== 1'b1 || a_ab !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_idle: ready %b aborted %b want 1 0", a_ready, a_ab);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_default();
      test_minimal();
      test_back_to_back();
`ifdef SERIES_CTRL_ABORT_EN
      test_abort();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
